timer_controller: RTL and testbench

TIMER_CONTROLLER -- requirements
Module: timer_controller

---
 rtl/timer_controller.sv | 165 ++++++++++++++++
 tb/tb_timer_controller.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_controller.sv
// -----------------------------------------------------------------------------
// timer_controller
//
// Two-digit BCD countdown timer with a load/run/pause/done control FSM.
// A prescaler divides clk by TICK_DIV. Each prescaler wrap decrements the
// count by one BCD step and raises a one-cycle tick. Reaching 00 parks the
// FSM in DONE until the next load.
//
// Parameters
//   TICK_DIV       clk cycles per count tick (>= 2)
//   PRESET_DEFAULT BCD {tens,units} loaded at reset (digits > 9 clamp to 9)
//
// Ports
//   clk      in   system clock, rising edge
//   reset    in   asynchronous active-low reset
//   load     in   load preset (IDLE/PAUSE/DONE only), highest priority
//   start    in   start/resume counting (count != 00), lowest priority
//   stop     in   pause counting (RUN only)
//   preset   in   BCD preset, tens in [7:4], units in [3:0]
//   units    out  BCD units digit of the current count
//   tens     out  BCD tens digit of the current count
//   running  out  high while in RUN
//   tick     out  one-cycle pulse per count decrement
//   done     out  high while in DONE
// -----------------------------------------------------------------------------
module timer_controller #(
    parameter int unsigned TICK_DIV       = 10000000,
    parameter logic [7:0]  PRESET_DEFAULT = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       start,
    input  logic       stop,
    input  logic [7:0] preset,
    output logic [3:0] units,
    output logic [3:0] tens,
    output logic       running,
    output logic       tick,
    output logic       done
);

    localparam int unsigned PW = $clog2(TICK_DIV);

    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    function automatic logic [3:0] clamp_digit(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    localparam logic [3:0] RST_TENS  = clamp_digit(PRESET_DEFAULT[7:4]);
    localparam logic [3:0] RST_UNITS = clamp_digit(PRESET_DEFAULT[3:0]);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StPause = 2'd2,
        StDone  = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    units_q, units_d;
    logic [3:0]    tens_q, tens_d;
    logic          tick_q, tick_d;
    logic          running_q, done_q;

    logic count_nz;
    logic last_step;

    assign count_nz  = (tens_q != 4'd0) || (units_q != 4'd0);
    // Decrement from 01 is the one that lands on 00.
    assign last_step = (tens_q == 4'd0) && (units_q == 4'd1);

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        units_d = units_q;
        tens_d  = tens_q;
        tick_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                presc_d = '0;
                if (load) begin
                    tens_d  = clamp_digit(preset[7:4]);
                    units_d = clamp_digit(preset[3:0]);
                end else if (!stop && start && count_nz) begin
                    state_d = StRun;
                end
            end

            StPause: begin
                if (load) begin
                    tens_d  = clamp_digit(preset[7:4]);
                    units_d = clamp_digit(preset[3:0]);
                    presc_d = '0;
                    state_d = StIdle;
                end else if (!stop && start && count_nz) begin
                    // Prescaler is kept so the paused fraction of a tick is honoured.
                    state_d = StRun;
                end
            end

            StRun: begin
                if (load || stop) begin
                    // Load is ignored in RUN but still masks lower requests and the tick.
                    if (!load) begin
                        state_d = StPause;
                    end
                end else if (presc_q == PRESC_MAX) begin
                    presc_d = '0;
                    tick_d  = 1'b1;
                    if (units_q == 4'd0) begin
                        units_d = 4'd9;
                        tens_d  = tens_q - 4'd1;
                    end else begin
                        units_d = units_q - 4'd1;
                    end
                    if (last_step) begin
                        state_d = StDone;
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end

            StDone: begin
                presc_d = '0;
                if (load) begin
                    tens_d  = clamp_digit(preset[7:4]);
                    units_d = clamp_digit(preset[3:0]);
                    state_d = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            presc_q   <= '0;
            tens_q    <= RST_TENS;
            units_q   <= RST_UNITS;
            tick_q    <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            tens_q    <= tens_d;
            units_q   <= units_d;
            tick_q    <= tick_d;
            running_q <= (state_d == StRun);
            done_q    <= (state_d == StDone);
        end
    end

    assign units   = units_q;
    assign tens    = tens_q;
    assign tick    = tick_q;
    assign running = running_q;
    assign done    = done_q;

endmodule

// File: tb/tb_timer_controller.sv
// -----------------------------------------------------------------------------
// tb_timer_controller
//
// Directed bench for timer_controller with TICK_DIV=4 and a reset preset of
// 8'h3B (clamps to 39). Inputs are driven and outputs sampled on the falling
// clock edge; every scenario task carries its own hand-derived expectations.
// -----------------------------------------------------------------------------
module tb_timer_controller;

    localparam int unsigned TICK_DIV       = 4;
    localparam logic [7:0]  PRESET_DEFAULT = 8'h3B;

    logic       clk = 1'b0;
    logic       reset;
    logic       load;
    logic       start;
    logic       stop;
    logic [7:0] preset;
    logic [3:0] units;
    logic [3:0] tens;
    logic       running;
    logic       tick;
    logic       done;

    int n_cmp = 0;
    int n_err = 0;

    timer_controller #(
        .TICK_DIV       (TICK_DIV),
        .PRESET_DEFAULT (PRESET_DEFAULT)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .start   (start),
        .stop    (stop),
        .preset  (preset),
        .units   (units),
        .tens    (tens),
        .running (running),
        .tick    (tick),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic pulse_load(input logic [7:0] p);
        preset = p;
        load   = 1'b1;
        @(negedge clk);
        load   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    task automatic test_reset();
        reset  = 1'b0;
        load   = 1'b0;
        start  = 1'b0;
        stop   = 1'b0;
        preset = 8'h00;
        @(negedge clk);
        n_cmp++;
        if ({tens, units} !== 8'h39) begin
            n_err++;
            $display("FAIL reset_count: got %h expected 39", {tens, units});
        end
        n_cmp++;
        if ({running, done, tick} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_flags: got %b expected 000", {running, done, tick});
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({tens, units, running, done, tick} !== {8'h39, 3'b000}) begin
            n_err++;
            $display("FAIL reset_idle: got %h/%b expected 39/000", {tens, units},
                     {running, done, tick});
        end
    endtask

    task automatic test_countdown();
        int         v;
        logic [7:0] exp;
        pulse_load(8'h12);
        n_cmp++;
        if ({tens, units, running} !== {8'h12, 1'b0}) begin
            n_err++;
            $display("FAIL cd_load: got %h run=%b expected 12 run=0", {tens, units}, running);
        end
        pulse_start();
        v = 12;
        for (int k = 0; k < 12; k++) begin
            for (int j = 0; j < 3; j++) begin
                @(negedge clk);
                n_cmp++;
                if (tick !== 1'b0) begin
                    n_err++;
                    $display("FAIL cd_gap: tick=%b expected 0 (step %0d)", tick, k);
                end
            end
            @(negedge clk);
            v--;
            exp = {4'(v / 10), 4'(v % 10)};
            n_cmp++;
            if ({tens, units, tick} !== {exp, 1'b1}) begin
                n_err++;
                $display("FAIL cd_tick: got %h tick=%b expected %h tick=1", {tens, units},
                         tick, exp);
            end
            n_cmp++;
            if ({running, done} !== ((v == 0) ? 2'b01 : 2'b10)) begin
                n_err++;
                $display("FAIL cd_flags: got run/done=%b at count %0d", {running, done}, v);
            end
        end
        // DONE ignores start and persists.
        pulse_start();
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({tens, units, running, done, tick} !== {8'h00, 3'b010}) begin
            n_err++;
            $display("FAIL done_hold: got %h/%b expected 00/010", {tens, units},
                     {running, done, tick});
        end
    endtask

    task automatic test_bcd_wrap();
        pulse_load(8'h10);
        n_cmp++;
        if ({done, running} !== 2'b00) begin
            n_err++;
            $display("FAIL wrap_load: done/run=%b expected 00", {done, running});
        end
        pulse_start();
        repeat (3) @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if ({tens, units, tick} !== {8'h09, 1'b1}) begin
            n_err++;
            $display("FAIL wrap_tick: got %h tick=%b expected 09 tick=1", {tens, units}, tick);
        end
    endtask

    task automatic test_load_priority();
        // Let the prescaler reach 1 before pausing so a stale PAUSE would tick early.
        @(negedge clk);
        pulse_stop();
        n_cmp++;
        if ({tens, units, running} !== {8'h09, 1'b0}) begin
            n_err++;
            $display("FAIL prio_pause: got %h run=%b expected 09 run=0", {tens, units}, running);
        end
        preset = 8'h34;
        load   = 1'b1;
        stop   = 1'b1;
        start  = 1'b1;
        @(negedge clk);
        load   = 1'b0;
        stop   = 1'b0;
        start  = 1'b0;
        n_cmp++;
        if ({tens, units, running, done} !== {8'h34, 2'b00}) begin
            n_err++;
            $display("FAIL prio_load: got %h run/done=%b expected 34/00", {tens, units},
                     {running, done});
        end
        repeat (5) @(negedge clk);
        n_cmp++;
        if ({tens, units, running, tick} !== {8'h34, 2'b00}) begin
            n_err++;
            $display("FAIL prio_idle: got %h run/tick=%b expected 34/00", {tens, units},
                     {running, tick});
        end
        pulse_start();
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            n_cmp++;
            if (tick !== 1'b0) begin
                n_err++;
                $display("FAIL prio_gap: tick=%b expected 0 (cycle %0d)", tick, j);
            end
        end
        @(negedge clk);
        n_cmp++;
        if ({tens, units, tick} !== {8'h33, 1'b1}) begin
            n_err++;
            $display("FAIL prio_tick: got %h tick=%b expected 33 tick=1", {tens, units}, tick);
        end
        pulse_stop();
    endtask

    task automatic test_pause_resume();
        pulse_load(8'h06);
        pulse_start();
        repeat (4) @(negedge clk);
        n_cmp++;
        if ({tens, units, tick} !== {8'h05, 1'b1}) begin
            n_err++;
            $display("FAIL pr_first: got %h tick=%b expected 05 tick=1", {tens, units}, tick);
        end
        repeat (2) @(negedge clk);
        pulse_stop();
        n_cmp++;
        if ({tens, units, running} !== {8'h05, 1'b0}) begin
            n_err++;
            $display("FAIL pr_stop: got %h run=%b expected 05 run=0", {tens, units}, running);
        end
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            n_cmp++;
            if ({tens, units, running, tick} !== {8'h05, 2'b00}) begin
                n_err++;
                $display("FAIL pr_hold: got %h run/tick=%b expected 05/00 (cycle %0d)",
                         {tens, units}, {running, tick}, j);
            end
        end
        pulse_start();
        n_cmp++;
        if ({running, tick} !== 2'b10) begin
            n_err++;
            $display("FAIL pr_resume: run/tick=%b expected 10", {running, tick});
        end
        @(negedge clk);
        n_cmp++;
        if (tick !== 1'b0) begin
            n_err++;
            $display("FAIL pr_gap: tick=%b expected 0", tick);
        end
        @(negedge clk);
        n_cmp++;
        if ({tens, units, tick} !== {8'h04, 1'b1}) begin
            n_err++;
            $display("FAIL pr_tick: got %h tick=%b expected 04 tick=1", {tens, units}, tick);
        end
        // Stop exactly on the terminal prescaler cycle: no tick, prescaler held at max.
        repeat (3) @(negedge clk);
        pulse_stop();
        n_cmp++;
        if ({tens, units, running, tick} !== {8'h04, 2'b00}) begin
            n_err++;
            $display("FAIL pr_stopmax: got %h run/tick=%b expected 04/00", {tens, units},
                     {running, tick});
        end
        pulse_start();
        n_cmp++;
        if ({running, tick} !== 2'b10) begin
            n_err++;
            $display("FAIL pr_resmax: run/tick=%b expected 10", {running, tick});
        end
        @(negedge clk);
        n_cmp++;
        if ({tens, units, tick} !== {8'h03, 1'b1}) begin
            n_err++;
            $display("FAIL pr_tickmax: got %h tick=%b expected 03 tick=1", {tens, units}, tick);
        end
        pulse_stop();
    endtask

    task automatic test_load_in_run();
        pulse_load(8'h02);
        pulse_start();
        pulse_load(8'h55);
        n_cmp++;
        if ({tens, units, running} !== {8'h02, 1'b1}) begin
            n_err++;
            $display("FAIL run_load: got %h run=%b expected 02 run=1", {tens, units}, running);
        end
        pulse_stop();
    endtask

    task automatic test_clamp();
        pulse_load(8'hAF);
        n_cmp++;
        if ({tens, units, running} !== {8'h99, 1'b0}) begin
            n_err++;
            $display("FAIL clamp_load: got %h run=%b expected 99 run=0", {tens, units}, running);
        end
        pulse_load(8'h00);
        pulse_start();
        n_cmp++;
        if ({tens, units, running} !== {8'h00, 1'b0}) begin
            n_err++;
            $display("FAIL zero_start: got %h run=%b expected 00 run=0", {tens, units}, running);
        end
        repeat (4) @(negedge clk);
        n_cmp++;
        if ({tens, units, running, done, tick} !== {8'h00, 3'b000}) begin
            n_err++;
            $display("FAIL zero_idle: got %h/%b expected 00/000", {tens, units},
                     {running, done, tick});
        end
    endtask

    task automatic test_reset_mid_run();
        pulse_load(8'h09);
        pulse_start();
        repeat (8) @(negedge clk);
        n_cmp++;
        if ({tens, units, tick, running} !== {8'h07, 2'b11}) begin
            n_err++;
            $display("FAIL mr_pre: got %h tick/run=%b expected 07/11", {tens, units},
                     {tick, running});
        end
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if ({tens, units, running, done, tick} !== {8'h39, 3'b000}) begin
            n_err++;
            $display("FAIL mr_async: got %h/%b expected 39/000", {tens, units},
                     {running, done, tick});
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({tens, units, running, tick} !== {8'h39, 2'b00}) begin
            n_err++;
            $display("FAIL mr_idle: got %h run/tick=%b expected 39/00", {tens, units},
                     {running, tick});
        end
        pulse_start();
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            n_cmp++;
            if ({tick, running} !== 2'b01) begin
                n_err++;
                $display("FAIL mr_gap: tick/run=%b expected 01 (cycle %0d)", {tick, running}, j);
            end
        end
        @(negedge clk);
        n_cmp++;
        if ({tens, units, tick} !== {8'h38, 1'b1}) begin
            n_err++;
            $display("FAIL mr_tick: got %h tick=%b expected 38 tick=1", {tens, units}, tick);
        end
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_bcd_wrap();
        test_load_priority();
        test_pause_resume();
        test_load_in_run();
        test_clamp();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
